// File: rtl/uart_pkg.sv
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared types, default rates and baud-divider rounding for the
//             UART transmit controller. Honours UART_TX_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package uart_pkg;

   localparam int unsigned C_CLOCK_RATE = 200_000_000;
   localparam int unsigned C_BAUD_RATE  = 115_200;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } tx_state_t;

   // Round-to-nearest integer divide of clock rate by bit rate
   function automatic int unsigned calc_baud_div(input int unsigned clock_rate,
                                                 input int unsigned baud_rate);
      return (clock_rate + (baud_rate / 2)) / baud_rate;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_ctl_if.sv
// ============================================================================
//  Module   : uart_tx_ctl_if
//  Purpose  : FIFO-side and line-side signal bundle of the UART transmitter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface uart_tx_ctl_if;

   logic       char_fifo_empty;
   logic [7:0] char_fifo_dout;
   logic       char_fifo_rd_en;
   logic       txd_tx;
   logic       tx_busy;

   modport master (
      input  char_fifo_empty,
      input  char_fifo_dout,
      output char_fifo_rd_en,
      output txd_tx,
      output tx_busy
   );

   modport slave (
      output char_fifo_empty,
      output char_fifo_dout,
      input  char_fifo_rd_en,
      input  txd_tx,
      input  tx_busy
   );

endinterface

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
//  Module   : uart_baud_gen
//  Purpose  : Bit-period timer; bit_done marks the last cycle of each bit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_baud_gen #(
   parameter int unsigned BAUD_DIV = 1736
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_done
);

   localparam int unsigned      C_CW   = $clog2(BAUD_DIV);
   localparam logic [C_CW-1:0]  C_LAST = C_CW'(BAUD_DIV - 1);

   generate
      if (BAUD_DIV < 4) begin : g_bad_div
         $error("uart_baud_gen: BAUD_DIV must be at least 4");
      end
   endgenerate

   logic [C_CW-1:0] r_cnt;

   // Clearing on the pop cycle aligns the first bit to a full period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clear || (r_cnt == C_LAST)) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign bit_done = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx_ctl.sv
// ============================================================================
//  Module   : uart_tx_ctl
//  Purpose  : Pops characters from a FWFT FIFO and serialises 8N1 frames
//             (8E1 when UART_TX_PARITY_EN is defined).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_tx_ctl
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_RATE = C_CLOCK_RATE,
   parameter int unsigned BAUD_RATE  = C_BAUD_RATE
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_ctl_if.master  bus
);

   localparam int unsigned BAUD_DIV = calc_baud_div(CLOCK_RATE, BAUD_RATE);

   tx_state_t  r_state;
   logic [7:0] r_shift;
   logic [2:0] r_idx;
   logic       r_txd;
   logic       r_busy;
`ifdef UART_TX_PARITY_EN
   logic       r_parity;
`endif

   logic       w_bit_done;
   logic       w_pop;

   // Pop from idle, or on the last stop cycle for gapless back-to-back frames
   assign w_pop = !rst && !bus.char_fifo_empty &&
                  ((r_state == IDLE) || ((r_state == STOP) && w_bit_done));

   assign bus.char_fifo_rd_en = w_pop;
   assign bus.txd_tx          = r_txd;
   assign bus.tx_busy         = r_busy;

   uart_baud_gen #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud_gen (
      .clk      (clk),
      .rst      (rst),
      .clear    (w_pop),
      .bit_done (w_bit_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_shift  <= 8'h00;
         r_idx    <= 3'd0;
         r_txd    <= 1'b1;
         r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity <= 1'b0;
`endif
      end else if (w_pop) begin
         r_state  <= START;
         r_shift  <= bus.char_fifo_dout;
         r_txd    <= 1'b0;
         r_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_parity <= ^bus.char_fifo_dout;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_txd  <= 1'b1;
               r_busy <= 1'b0;
            end
            START: begin
               if (w_bit_done) begin
                  r_txd   <= r_shift[0];
                  r_state <= DATA;
               end
            end
            DATA: begin
               if (w_bit_done) begin
                  if (r_idx == 3'd7) begin
                     r_idx   <= 3'd0;
`ifdef UART_TX_PARITY_EN
                     r_txd   <= r_parity;
                     r_state <= PARITY;
`else
                     r_txd   <= 1'b1;
                     r_state <= STOP;
`endif
                  end else begin
                     r_idx   <= r_idx + 3'd1;
                     r_shift <= r_shift >> 1;
                     r_txd   <= r_shift[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (w_bit_done) begin
                  r_txd   <= 1'b1;
                  r_state <= STOP;
               end
            end
`endif
            STOP: begin
               if (w_bit_done) begin
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_txd   <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctl.sv
// ============================================================================
//  Module   : tb_uart_tx_ctl
//  Purpose  : Randomised self-checking bench for uart_tx_ctl with a
//             frame-level line model and a serial receiver.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_ctl;

   localparam int unsigned CLK_RATE = 1_000_000;
   localparam int unsigned BAUD     = 90_000;
   localparam int          D        = (CLK_RATE + BAUD / 2) / BAUD;
`ifdef UART_TX_PARITY_EN
   localparam int          NBITS    = 11;
`else
   localparam int          NBITS    = 10;
`endif
   localparam int          FRAME    = NBITS * D;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_tx_ctl_if bus();

   uart_tx_ctl #(
      .CLOCK_RATE (CLK_RATE),
      .BAUD_RATE  (BAUD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] fifo_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] rx_q[$];
   int         frm_err  = 0;
   logic [7:0] cur_c    = 8'h00;
   int         m_left   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Line level of bit b of a frame carrying character c
   function automatic logic frame_level(input logic [7:0] c, input int b);
      if (b == 0) return 1'b0;
      if (b <= 8) return c[b-1];
`ifdef UART_TX_PARITY_EN
      if (b == 9) return ^c;
`endif
      return 1'b1;
   endfunction

   task automatic drive_fifo();
      bus.char_fifo_empty = (fifo_q.size() == 0);
      bus.char_fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
   endtask

   task automatic push(input logic [7:0] c);
      fifo_q.push_back(c);
      drive_fifo();
   endtask

   task automatic check_outputs();
      logic e_txd;
      e_txd = (m_left == 0) ? 1'b1 : frame_level(cur_c, (FRAME - m_left) / D);
      check_eq("txd_tx", bus.txd_tx, e_txd);
      check_eq("tx_busy", bus.tx_busy, m_left != 0);
      check_eq("rd_en", bus.char_fifo_rd_en, !rst && fifo_q.size() != 0 && m_left <= 1);
   endtask

   // One clock: advance the model at the edge, compare on the falling edge
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         if (m_left > 0) void'(exp_q.pop_back());
         m_left = 0;
      end else if (fifo_q.size() != 0 && m_left <= 1) begin
         cur_c  = fifo_q.pop_front();
         exp_q.push_back(cur_c);
         m_left = FRAME;
      end else if (m_left > 0) begin
         m_left--;
      end
      #1 drive_fifo();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while ((fifo_q.size() != 0 || m_left != 0) && n < budget) begin
         tick();
         n++;
      end
      check_eq("drain_done", (fifo_q.size() == 0 && m_left == 0), 1);
      repeat (3) tick();
   endtask

   // Serial receiver sampling mid-bit; frames cut by reset are discarded
   logic [NBITS-1:0] mon_bits;
   bit               mon_ok;
   initial begin
      forever begin
         @(negedge bus.txd_tx);
         mon_ok = !rst;
         for (int b = 0; b < NBITS && mon_ok; b++) begin
            for (int k = 0; k < ((b == 0) ? D / 2 : D) && mon_ok; k++) begin
               @(posedge clk);
               #1;
               if (rst) mon_ok = 1'b0;
            end
            mon_bits[b] = bus.txd_tx;
         end
         if (mon_ok) begin
            if (mon_bits[0] !== 1'b0 || mon_bits[NBITS-1] !== 1'b1) frm_err++;
`ifdef UART_TX_PARITY_EN
            if (mon_bits[9] !== ^mon_bits[8:1]) frm_err++;
`endif
            rx_q.push_back(mon_bits[8:1]);
         end
      end
   end

   initial begin
      int cnt;
      bus.char_fifo_empty = 1'b1;
      bus.char_fifo_dout  = 8'h00;

      repeat (4) tick();
      #2 rst = 1'b0;

      // Long idle with an empty FIFO
      repeat (2000) tick();

      push(8'h55);
      drain(4 * FRAME);

      push(8'h41);
      push(8'h42);
      drain(4 * FRAME);

      for (int i = 0; i < 25; i++) begin
         push(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) push(8'($urandom_range(0, 255)));
         repeat ($urandom_range(0, FRAME + FRAME / 2)) tick();
      end
      drain(60 * FRAME);

      // Reset in the middle of data bit 3 of 0xA5
      push(8'hA5);
      cnt = 0;
      while (!(m_left != 0 && (FRAME - m_left) / D == 4 && (FRAME - m_left) % D == D / 2)
             && cnt < 4 * FRAME) begin
         tick();
         cnt++;
      end
      check_eq("reach_bit3", m_left != 0 && (FRAME - m_left) / D == 4, 1);
      push(8'h3C);
      #2 rst = 1'b1;
      #1;
      check_eq("rst_txd", bus.txd_tx, 1'b1);
      check_eq("rst_busy", bus.tx_busy, 1'b0);
      check_eq("rst_rd_en", bus.char_fifo_rd_en, 1'b0);
      repeat (3) tick();
      #2 rst = 1'b0;
      drain(4 * FRAME);

      push(8'h07);
      push(8'h03);
      drain(4 * FRAME);

      check_eq("rx_count", rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
         check_eq("rx_char", rx_q[i], exp_q[i]);
      end
      check_eq("framing_errors", frm_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_tx_ctl.md
UART_TX_CTL -- requirements
Module: uart_tx_ctl

Interface
REQ-001 Parameter CLOCK_RATE, default 200_000_000: clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115_200: line bit rate in bit/s.
REQ-003 Port clk  input  1: single clock; all logic is rising-edge triggered.
REQ-004 Port rst  input  1: reset, asynchronous assert, active-high.
REQ-005 Port char_fifo_empty  input  1: high when the first-word-fall-through character FIFO is empty.
REQ-006 Port char_fifo_dout  input  8: FIFO head character, valid whenever char_fifo_empty is low.
REQ-007 Port char_fifo_rd_en  output  1: one-cycle pop strobe to the FIFO.
REQ-008 Port txd_tx  output  1: serial line, registered, idle high.
REQ-009 Port tx_busy  output  1: high while a frame is on the line.

Function
REQ-010 Bit period SHALL be BAUD_DIV = round(CLOCK_RATE/BAUD_RATE) clk cycles (1736 at defaults).
REQ-011 Elaboration SHALL fail if BAUD_DIV < 4.
REQ-012 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-013 IDLE with char_fifo_empty low: assert char_fifo_rd_en for exactly one cycle, latch char_fifo_dout that cycle, go to START.
REQ-014 char_fifo_rd_en SHALL never assert while char_fifo_empty is high.
REQ-015 Baud counter SHALL be cleared on the pop cycle, so each bit lasts exactly BAUD_DIV cycles.
REQ-016 txd_tx SHALL go low on the cycle after the pop.
REQ-017 START: txd_tx=0 for BAUD_DIV cycles, then DATA.
REQ-018 DATA: 8 bits, LSB first, BAUD_DIV cycles each; 3-bit index wraps 7->0 on exit.
REQ-019 After bit 7 the FSM SHALL go to PARITY when configured (REQ-028), else STOP.
REQ-020 STOP: txd_tx=1 for BAUD_DIV cycles.
REQ-021 On the last STOP cycle, if char_fifo_empty is low, the pop SHALL happen that cycle and the FSM SHALL go directly to START: back-to-back frames with no idle gap.
REQ-022 On the last STOP cycle, if char_fifo_empty is high, the FSM SHALL go to IDLE.
REQ-023 tx_busy SHALL be high from the cycle after a pop through the last STOP cycle, and low in IDLE.
REQ-024 char_fifo_empty rising mid-frame SHALL have no effect on the frame in progress.

Reset
REQ-025 rst high SHALL immediately force txd_tx=1, char_fifo_rd_en=0, tx_busy=0, state IDLE, counters 0, shift register 0.
REQ-026 Reset mid-frame SHALL abort the frame; the popped character is lost and is not resent.
REQ-027 The first pop after reset release SHALL occur no earlier than the first rising edge with rst low.

Configuration
REQ-028 Macro UART_TX_PARITY_EN defined: PARITY state is compiled in and sends an even-parity bit (XOR of the 8 data bits) for BAUD_DIV cycles between bit 7 and STOP; a frame is 11*BAUD_DIV cycles.
REQ-029 Macro UART_TX_PARITY_EN undefined: PARITY state and parity logic are absent; a frame is 10*BAUD_DIV cycles.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state typedef, the default CLOCK_RATE/BAUD_RATE constants, and the BAUD_DIV rounding function.
REQ-031 Sub-module uart_baud_gen (parameter BAUD_DIV; inputs clk, rst, clear; output bit_done pulse) SHALL provide bit timing.
REQ-032 All FSM, shift and index logic SHALL reside in uart_tx_ctl.

Verification
REQ-033 FIFO holds 0x55 at default parameters -> one rd_en pulse; txd_tx = 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop), each level 1736 cycles; tx_busy high 17360 cycles.
REQ-034 FIFO holds 0x41 then 0x42 -> second start bit begins the cycle after the first stop bit ends, with no idle-high gap; exactly two rd_en pulses.
REQ-035 FIFO empty for 100_000 cycles after reset -> txd_tx constantly 1, rd_en never asserted, tx_busy 0.
REQ-036 rst pulsed during data bit 3 of 0xA5 -> txd_tx=1 and tx_busy=0 immediately; after release, 0x3C in the FIFO is sent as a complete frame starting from its start bit.
REQ-037 With UART_TX_PARITY_EN defined, 0x07 sent -> parity bit 1 and frame 19096 cycles; 0x03 sent -> parity bit 0.
REQ-038 Bench uart monitor decoding at BAUD_RATE SHALL report every sent character with no framing error in all scenarios.
